// File: rtl/midi_rx_parser.sv
// MIDI serial receiver and message assembler: synchronizes midi_rx, recovers 8N1 bytes,
// and groups them into channel/real-time messages with running status.
`timescale 1ns/1ps
module midi_rx_parser #(
    parameter int CLKS_PER_BIT = 3200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       midi_rx,
    output logic [7:0] status,
    output logic [7:0] data1,
    output logic [7:0] data2,
    output logic [1:0] bytes_cnt,
    output logic       msg_valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_e;

    // Program change and channel pressure carry one data byte, all other channel messages two.
    function automatic logic [1:0] data_needed(input logic [7:0] s);
        return (s[7:5] == 3'b110) ? 2'd1 : 2'd2;
    endfunction

    logic [1:0]       sync_q, sync_d;
    logic             prev_q, prev_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       run_status_q, run_status_d;
    logic             data_idx_q, data_idx_d;
    logic [7:0]       pend_d1_q, pend_d1_d;
    logic [7:0]       status_q, status_d;
    logic [7:0]       data1_q, data1_d;
    logic [7:0]       data2_q, data2_d;
    logic [1:0]       bytes_cnt_q, bytes_cnt_d;
    logic             msg_valid_q, msg_valid_d;
    logic             rx_line_s;

    assign rx_line_s = sync_q[1];
    assign sync_d    = {sync_q[0], midi_rx};
    assign prev_d    = sync_q[1];

    // Byte receiver: start-bit qualification, centre sampling of data and stop bits.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (prev_q && !rx_line_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_line_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_line_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_line_s) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (rx_line_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Message assembly; bit 7 of run_status_q doubles as the running-status valid flag.
    always_comb begin
        run_status_d = run_status_q;
        data_idx_d   = data_idx_q;
        pend_d1_d    = pend_d1_q;
        status_d     = status_q;
        data1_d      = data1_q;
        data2_d      = data2_q;
        bytes_cnt_d  = bytes_cnt_q;
        msg_valid_d  = 1'b0;
        if (rx_valid_q) begin
            if (rx_byte_q[7:3] == 5'b11111) begin
                status_d    = rx_byte_q;
                data1_d     = 8'h00;
                data2_d     = 8'h00;
                bytes_cnt_d = 2'd1;
                msg_valid_d = 1'b1;
            end else if (rx_byte_q[7:4] == 4'hF) begin
                run_status_d = 8'h00;
                data_idx_d   = 1'b0;
            end else if (rx_byte_q[7]) begin
                run_status_d = rx_byte_q;
                data_idx_d   = 1'b0;
            end else if (!run_status_q[7]) begin
                data_idx_d = 1'b0;
            end else if (!data_idx_q) begin
                if (data_needed(run_status_q) == 2'd1) begin
                    status_d    = run_status_q;
                    data1_d     = rx_byte_q;
                    data2_d     = 8'h00;
                    bytes_cnt_d = 2'd2;
                    msg_valid_d = 1'b1;
                end else begin
                    pend_d1_d  = rx_byte_q;
                    data_idx_d = 1'b1;
                end
            end else begin
                status_d    = run_status_q;
                data1_d     = pend_d1_q;
                data2_d     = rx_byte_q;
                bytes_cnt_d = 2'd3;
                msg_valid_d = 1'b1;
                data_idx_d  = 1'b0;
            end
        end else begin
            msg_valid_d = 1'b0;
        end
    end

    // State register for synchronizer, receiver and parser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= 2'b11;
            prev_q       <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            rx_byte_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            run_status_q <= 8'h00;
            data_idx_q   <= 1'b0;
            pend_d1_q    <= 8'h00;
            status_q     <= 8'h00;
            data1_q      <= 8'h00;
            data2_q      <= 8'h00;
            bytes_cnt_q  <= 2'd0;
            msg_valid_q  <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            run_status_q <= run_status_d;
            data_idx_q   <= data_idx_d;
            pend_d1_q    <= pend_d1_d;
            status_q     <= status_d;
            data1_q      <= data1_d;
            data2_q      <= data2_d;
            bytes_cnt_q  <= bytes_cnt_d;
            msg_valid_q  <= msg_valid_d;
        end
    end

    assign status    = status_q;
    assign data1     = data1_q;
    assign data2     = data2_q;
    assign bytes_cnt = bytes_cnt_q;
    assign msg_valid = msg_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_midi_rx_parser.sv
// Directed bench for midi_rx_parser at 16 clocks per bit; expected messages and frame
// errors are queued with their due cycle and matched by a negedge monitor.
`timescale 1ns/1ps
module tb_midi_rx_parser;

    localparam int CPB = 16;
    // Start driven just after edge n: stop bit sampled at edge n+155, message one edge later.
    localparam int FE_LAT  = 155;
    localparam int MSG_LAT = 156;

    typedef struct {
        logic [7:0] st;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [1:0] n;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       midi_rx = 1'b1;
    logic [7:0] status, data1, data2;
    logic [1:0] bytes_cnt;
    logic       msg_valid, frame_err;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t msg_q[$];
    int   fe_q[$];
    exp_t e_m;
    int   fe_m;

    midi_rx_parser #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .midi_rx   (midi_rx),
        .status    (status),
        .data1     (data1),
        .data2     (data2),
        .bytes_cnt (bytes_cnt),
        .msg_valid (msg_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Scoreboard side: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (msg_valid) begin
            check("msg_expected", 32'(msg_q.size() > 0), 32'd1);
            if (msg_q.size() > 0) begin
                e_m = msg_q.pop_front();
                check("msg_cycle", 32'(cyc), 32'(e_m.cyc));
                check("status", 32'(status), 32'(e_m.st));
                check("data1", 32'(data1), 32'(e_m.d1));
                check("data2", 32'(data2), 32'(e_m.d2));
                check("bytes_cnt", 32'(bytes_cnt), 32'(e_m.n));
            end
        end
        if (frame_err) begin
            check("fe_expected", 32'(fe_q.size() > 0), 32'd1);
            if (fe_q.size() > 0) begin
                fe_m = fe_q.pop_front();
                check("fe_cycle", 32'(cyc), 32'(fe_m));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit push,
                             input logic [7:0] st, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [1:0] n);
        int n0;
        @(posedge clk);
        #1;
        n0 = cyc;
        if (push) msg_q.push_back('{st, d1, d2, n, n0 + MSG_LAT});
        if (!stop_ok) fe_q.push_back(n0 + FE_LAT);
        midi_rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 midi_rx = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 midi_rx = stop_ok;
        repeat (CPB) @(posedge clk);
        if (!stop_ok) begin
            repeat (40) @(posedge clk);
            #1 midi_rx = 1'b1;
            repeat (CPB) @(posedge clk);
        end
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_status"}, 32'(status), 32'd0);
        check({tag, "_data1"}, 32'(data1), 32'd0);
        check({tag, "_data2"}, 32'(data2), 32'd0);
        check({tag, "_bytes_cnt"}, 32'(bytes_cnt), 32'd0);
        check({tag, "_msg_valid"}, 32'(msg_valid), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        check("reset_state", 32'(dut.state_q), 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Full three-byte note-on.
        send(8'h90);
        send(8'h3C);
        send_byte(8'h64, 1'b1, 1'b1, 8'h90, 8'h3C, 8'h64, 2'd3);

        // Program change, then a running-status repeat.
        send(8'hC0);
        send_byte(8'h42, 1'b1, 1'b1, 8'hC0, 8'h42, 8'h00, 2'd2);
        send_byte(8'h43, 1'b1, 1'b1, 8'hC0, 8'h43, 8'h00, 2'd2);

        // Real-time clock in the middle of a control change.
        send(8'hB0);
        send(8'h2E);
        send_byte(8'hF8, 1'b1, 1'b1, 8'hF8, 8'h00, 8'h00, 2'd1);
        send_byte(8'h7F, 1'b1, 1'b1, 8'hB0, 8'h2E, 8'h7F, 2'd3);

        // System exclusive start clears running status: later data is ignored.
        send(8'hF0);
        send(8'h11);

        // Status byte lost to a framing error, so following data has no status.
        send_byte(8'h90, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
        send(8'h3C);
        send(8'h64);

        // A framing error inside a message leaves the partial message intact.
        send(8'h90);
        send(8'h3C);
        send_byte(8'h55, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
        send_byte(8'h64, 1'b1, 1'b1, 8'h90, 8'h3C, 8'h64, 2'd3);

        // Short low glitch is rejected at the start-bit centre.
        @(posedge clk);
        #1 midi_rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 midi_rx = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("glitch_idle", 32'(dut.state_q), 32'd0);

        // Reset in the middle of 0x80's data bits; the line finishes the byte meanwhile.
        @(posedge clk);
        #1 midi_rx = 1'b0;
        repeat (60) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("midbyte_rst");
        repeat (66) @(posedge clk);
        #1 midi_rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_release_state", 32'(dut.state_q), 32'd0);
        send(8'h3C);
        repeat (20) @(posedge clk);
        #1;
        check_outputs_zero("after_rst_data");

        check("msg_queue_drained", 32'(msg_q.size()), 32'd0);
        check("fe_queue_drained", 32'(fe_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/midi_rx_parser.md
MIDI_RX_PARSER -- requirements
Module: midi_rx_parser

Interface
REQ-001 Parameter CLKS_PER_BIT, default 3200, clk cycles per MIDI bit (31250 baud at 100 MHz); SHALL be even and >= 8.
REQ-002 Port clk  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-003 Port rst  input  1  reset; asynchronous, active-high.
REQ-004 Port midi_rx  input  1  serial MIDI line, asynchronous to clk, idle high.
REQ-005 Port status  output  8  status byte of the last completed message.
REQ-006 Port data1  output  8  first data byte; 0 when the message has no data bytes.
REQ-007 Port data2  output  8  second data byte; 0 when the message has fewer than two data bytes.
REQ-008 Port bytes_cnt  output  2  total bytes in the message, 1..3, status byte included.
REQ-009 Port msg_valid  output  1  one-cycle pulse; status/data1/data2/bytes_cnt valid on that cycle and held until the next pulse.
REQ-010 Port frame_err  output  1  one-cycle pulse on a missing stop bit.

Function
REQ-011 midi_rx SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value only.
REQ-012 The byte receiver FSM SHALL have exactly the states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-013 IDLE -> START on a synchronized high-to-low transition; the bit counter SHALL clear.
REQ-014 START SHALL sample the line at count CLKS_PER_BIT/2-1; low -> DATA; high -> IDLE (glitch, no output).
REQ-015 DATA SHALL sample every CLKS_PER_BIT cycles from the start-bit centre, 8 bits, LSB first.
REQ-016 STOP SHALL sample one CLKS_PER_BIT later; high -> byte accepted, IDLE; low -> frame_err pulse, byte discarded, WAIT_IDLE.
REQ-017 WAIT_IDLE SHALL stay until the synchronized line is high, then go to IDLE.
REQ-018 Accepted byte 0x80-0xEF SHALL become the running status, abort any partial message, and set the expected data count: 1 for 0xC0-0xDF, otherwise 2.
REQ-019 Accepted byte 0xF0-0xF7 SHALL clear running status, abort any partial message, and produce no msg_valid.
REQ-020 Accepted byte 0xF8-0xFF (real-time) SHALL emit a 1-byte message: status=byte, data1=data2=0, bytes_cnt=1. It SHALL leave running status and any partial message intact.
REQ-021 Accepted byte 0x00-0x7F with no running status SHALL be discarded.
REQ-022 Otherwise a data byte SHALL fill data1 and then data2. When the expected count is reached, msg_valid SHALL pulse with bytes_cnt = count+1.
REQ-023 After a complete message the data index SHALL reset and running status SHALL be retained, so later data bytes form new messages with the same status.
REQ-024 msg_valid SHALL assert exactly 1 clk after the clk edge that samples the stop bit of the final byte.
REQ-025 Partial message state SHALL survive a framing error; the errored byte SHALL have no effect on it.

Reset
REQ-026 While rst is high: FSM=IDLE, counters=0, synchronizer=1, running status cleared, partial message cleared, status=data1=data2=0, bytes_cnt=0, msg_valid=0, frame_err=0.
REQ-027 rst asserted mid-byte SHALL discard the byte. After release, reception SHALL restart only on a new falling edge.

Verification (CLKS_PER_BIT=16)
REQ-028 Send 0x90,0x3C,0x64 -> one msg_valid with status=0x90, data1=0x3C, data2=0x64, bytes_cnt=3, 1 clk after the third stop-bit sample.
REQ-029 Send 0xC0,0x42, then 0x43 -> two pulses: (0xC0,0x42,0,2), then running status (0xC0,0x43,0,2).
REQ-030 Send 0xB0,0x2E,0xF8,0x7F -> pulse (0xF8,0,0,1), then pulse (0xB0,0x2E,0x7F,3).
REQ-031 Send 0x90 with stop bit forced low, line held low 40 clks -> frame_err single pulse, no msg_valid. After line high, send 0x3C,0x64 -> no output (0x90 discarded).
REQ-032 Drive a 5-clk low glitch on midi_rx -> no frame_err, no msg_valid, FSM back in IDLE.
REQ-033 Assert rst during the data bits of 0x80 -> all outputs 0. Then send 0x3C -> discarded, no msg_valid.
